// File: rtl/flash_count_decoder_pkg.sv
// Shared types and helpers for the flash-count decoder.
//   fcd_state_e : decoder FSM states
//   CNT_W       : decoded count width, matches the LED flasher's flash count
//   sat_inc()   : saturating increment of a count value
package flash_count_decoder_pkg;

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        StIdle,
        StOn,
        StGap,
        StEmit,
        StHold
    } fcd_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/flash_count_decoder_input_debounce.sv
// Input conditioning for a raw asynchronous pin: polarity fix, 2-FF synchronizer and
// debounce, producing single-cycle strobes on each accepted level change.
//   clk, rst : clock, asynchronous active-high reset (debounced level resets inactive)
//   pin_in   : raw asynchronous input
//   rise     : 1-cycle strobe, debounced level goes active
//   fall     : 1-cycle strobe, debounced level goes inactive
module input_debounce #(
    parameter int unsigned DB_W        = 16,
    parameter bit          ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    output logic rise,
    output logic fall
);

    logic            pol;
    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic [DB_W:0]   db_cnt_q;
    logic [DB_W:0]   db_cnt_d;
    logic            flip;

    assign pol = ACTIVE_HIGH ? pin_in : ~pin_in;

    // The level flips on the cycle the disagreement count reaches 2^DB_W, so the
    // synchronized input must disagree for 2^DB_W consecutive cycles.
    always_comb begin
        db_cnt_d = db_cnt_q;
        flip     = 1'b0;
        if (sync2_q == level_q) begin
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
            if (db_cnt_d[DB_W]) begin
                flip     = 1'b1;
                db_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= pol;
            sync2_q  <= sync1_q;
            db_cnt_q <= db_cnt_d;
            if (flip) begin
                level_q <= ~level_q;
            end
        end
    end

    assign rise = flip & ~level_q;
    assign fall = flip & level_q;

endmodule

// File: rtl/flash_count_decoder.sv
// Decodes a train of pulses on a button/opto input into a 4-bit count, reported once
// after an idle gap of 2^DW cycles. A press longer than 2^DW cycles aborts the sequence.
//   clk, rst  : clock, asynchronous active-high reset
//   pin_in    : raw asynchronous input
//   cnt_out   : decoded count, held until the next report
//   cnt_valid : 1-cycle strobe, new count on cnt_out
//   cnt_ovf   : more than 15 pulses seen (cnt_out saturated at 15)
//   abort     : 1-cycle strobe, sequence discarded by a long press
//   busy      : sequence in progress
module flash_count_decoder
    import flash_count_decoder_pkg::*;
#(
    parameter int unsigned DW          = 21,
    parameter int unsigned DB_W        = 16,
    parameter bit          ACTIVE_HIGH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pin_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    output logic             cnt_ovf,
    output logic             abort,
    output logic             busy
);

    logic             rise;
    logic             fall;
    logic [DW:0]      timer_q;
    logic             tick;
    fcd_state_e       state_q;
    fcd_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             emit;
    logic             long_press;
    logic [CNT_W-1:0] cnt_out_q;
    logic             ovf_out_q;
    logic             valid_q;
    logic             abort_q;

    input_debounce #(
        .DB_W        (DB_W),
        .ACTIVE_HIGH (ACTIVE_HIGH)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .pin_in (pin_in),
        .rise   (rise),
        .fall   (fall)
    );

    assign tick = timer_q[DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (rise || fall || tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        emit       = 1'b0;
        long_press = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StOn;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                end
            end
            StOn: begin
                // A release on the tick cycle still counts as a normal pulse.
                if (fall) begin
                    state_d = StGap;
                end else if (tick) begin
                    state_d    = StHold;
                    long_press = 1'b1;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                end
            end
            StGap: begin
                // A new pulse landing on the tick cycle extends the sequence.
                if (rise) begin
                    state_d = StOn;
                    cnt_d   = sat_inc(cnt_q);
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end
                end else if (tick) begin
                    state_d = StEmit;
                    emit    = 1'b1;
                end
            end
            StEmit: begin
                state_d = StIdle;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
            StHold: begin
                if (fall) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Report registers load on the transition into EMIT so the count is presented
    // together with the strobe during the EMIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_out_q <= '0;
            ovf_out_q <= 1'b0;
            valid_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= emit;
            abort_q <= long_press;
            if (emit) begin
                cnt_out_q <= cnt_q;
                ovf_out_q <= ovf_q;
            end
        end
    end

    assign cnt_out   = cnt_out_q;
    assign cnt_ovf   = ovf_out_q;
    assign cnt_valid = valid_q;
    assign abort     = abort_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_flash_count_decoder.sv
// Bench for flash_count_decoder: drives one random pin pattern into an active-high
// instance and (inverted) into an active-low instance, and compares both against a
// pulse-counting reference model every cycle, plus per-scenario expected counts.
module tb_flash_count_decoder;

    localparam int unsigned DW       = 4;
    localparam int unsigned DB_W     = 2;
    localparam int          TICK_AGE = (1 << DW) + 1;
    localparam int          DB_LEN   = 1 << DB_W;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pin = 1'b0;
    logic       pin_n;
    logic [3:0] cnt_hi, cnt_lo;
    logic       valid_hi, valid_lo, ovf_hi, ovf_lo, abort_hi, abort_lo, busy_hi, busy_lo;

    assign pin_n = ~pin;

    flash_count_decoder #(.DW(DW), .DB_W(DB_W), .ACTIVE_HIGH(1'b1)) dut_hi (
        .clk       (clk),
        .rst       (rst),
        .pin_in    (pin),
        .cnt_out   (cnt_hi),
        .cnt_valid (valid_hi),
        .cnt_ovf   (ovf_hi),
        .abort     (abort_hi),
        .busy      (busy_hi)
    );

    flash_count_decoder #(.DW(DW), .DB_W(DB_W), .ACTIVE_HIGH(1'b0)) dut_lo (
        .clk       (clk),
        .rst       (rst),
        .pin_in    (pin_n),
        .cnt_out   (cnt_lo),
        .cnt_valid (valid_lo),
        .cnt_ovf   (ovf_lo),
        .abort     (abort_lo),
        .busy      (busy_lo)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int nvalid   = 0;
    int nabort   = 0;

    // Reference model state: debounced level, pulse count of the open sequence,
    // cycles since the last accepted edge.
    bit s1_m = 0, s2_m = 0, lvl_m = 0, held_m = 0, emit_m = 0;
    int run_m = 0, age_m = 0, pulses_m = 0;
    bit exp_valid = 0, exp_abort = 0, exp_busy = 0, exp_ovf = 0;
    int exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit r, f, lvl_pre, tick_now;
        if (rst) begin
            s1_m = 0; s2_m = 0; lvl_m = 0; run_m = 0; age_m = 0;
            pulses_m = 0; held_m = 0; emit_m = 0;
            exp_valid = 0; exp_abort = 0; exp_busy = 0; exp_cnt = 0; exp_ovf = 0;
        end else begin
            r = 0;
            f = 0;
            lvl_pre  = lvl_m;
            tick_now = (age_m == TICK_AGE);
            if (s2_m != lvl_m) begin
                run_m++;
                if (run_m == DB_LEN) begin
                    r = ~lvl_m;
                    f = lvl_m;
                    lvl_m = ~lvl_m;
                    run_m = 0;
                end
            end else begin
                run_m = 0;
            end
            s2_m  = s1_m;
            s1_m  = pin;
            age_m = (r || f) ? 1 : age_m + 1;
            exp_valid = 0;
            exp_abort = 0;
            if (emit_m) begin
                emit_m = 0;
            end else if (held_m) begin
                if (f) held_m = 0;
            end else if (pulses_m == 0) begin
                if (r) pulses_m = 1;
            end else if (lvl_pre) begin
                if (!f && tick_now) begin
                    exp_abort = 1;
                    pulses_m  = 0;
                    held_m    = 1;
                end
            end else begin
                if (r) begin
                    pulses_m++;
                end else if (tick_now) begin
                    exp_valid = 1;
                    exp_cnt   = (pulses_m > 15) ? 15 : pulses_m;
                    exp_ovf   = (pulses_m > 15);
                    pulses_m  = 0;
                    emit_m    = 1;
                end
            end
            exp_busy = (pulses_m > 0) || held_m || emit_m;
        end
    endtask

    task automatic cycle_check();
        bit ev, ea, eb, eo;
        int ec;
        ev = rst ? 1'b0 : exp_valid;
        ea = rst ? 1'b0 : exp_abort;
        eb = rst ? 1'b0 : exp_busy;
        eo = rst ? 1'b0 : exp_ovf;
        ec = rst ? 0 : exp_cnt;
        check("hi.cnt_valid", 32'(valid_hi), 32'(ev));
        check("hi.abort",     32'(abort_hi), 32'(ea));
        check("hi.busy",      32'(busy_hi),  32'(eb));
        check("hi.cnt_out",   32'(cnt_hi),   32'(ec));
        check("hi.cnt_ovf",   32'(ovf_hi),   32'(eo));
        check("lo.cnt_valid", 32'(valid_lo), 32'(ev));
        check("lo.abort",     32'(abort_lo), 32'(ea));
        check("lo.busy",      32'(busy_lo),  32'(eb));
        check("lo.cnt_out",   32'(cnt_lo),   32'(ec));
        check("lo.cnt_ovf",   32'(ovf_lo),   32'(eo));
        if (valid_hi === 1'b1) nvalid++;
        if (abort_hi === 1'b1) nabort++;
    endtask

    // Each cycle: check outputs mid-cycle, advance the model at the edge, drive at edge+1.
    task automatic step();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit v, input int n);
        pin = v;
        repeat (n) step();
    endtask

    task automatic train(input int n, input int hmin, input int hmax, input int lmin,
                         input int lmax, input int idle);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, $urandom_range(hmax, hmin));
            if (i < n - 1) drive(1'b0, $urandom_range(lmax, lmin));
        end
        drive(1'b0, idle);
    endtask

    task automatic check_report(input string tag, input int v0, input int cnt, input bit ovf);
        check({tag, ".nvalid"}, 32'(nvalid - v0), 32'd1);
        check({tag, ".cnt_hi"}, 32'(cnt_hi), 32'(cnt));
        check({tag, ".cnt_lo"}, 32'(cnt_lo), 32'(cnt));
        check({tag, ".ovf_hi"}, 32'(ovf_hi), 32'(ovf));
        check({tag, ".ovf_lo"}, 32'(ovf_lo), 32'(ovf));
    endtask

    initial begin
        int v0, a0;
        #1 rst = 1'b1;
        drive(1'b0, 3);
        rst = 1'b0;
        drive(1'b0, 5);

        // Three clean 8/8 pulses.
        v0 = nvalid;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8);
            drive(1'b0, 8);
        end
        drive(1'b0, 32);
        check_report("clean3", v0, 3, 1'b0);

        // Short glitches while idle, then inside a gap.
        v0 = nvalid;
        drive(1'b1, 1); drive(1'b0, 10); drive(1'b1, 3); drive(1'b0, 30);
        check("glitch_idle.nvalid", 32'(nvalid - v0), 32'd0);
        drive(1'b1, 8); drive(1'b0, 4); drive(1'b1, 3); drive(1'b0, 5);
        drive(1'b1, 1); drive(1'b0, 40);
        check_report("glitch_gap", v0, 1, 1'b0);

        // Overflow: 18 pulses saturate, next short train reports cleanly.
        v0 = nvalid;
        train(18, 5, 8, 5, 10, 40);
        check_report("ovf18", v0, 15, 1'b1);
        v0 = nvalid;
        train(2, 5, 8, 5, 10, 40);
        check_report("after_ovf", v0, 2, 1'b0);

        // Long press aborts, then a single pulse.
        v0 = nvalid;
        a0 = nabort;
        drive(1'b1, 40);
        drive(1'b0, 40);
        check("long.nabort", 32'(nabort - a0), 32'd1);
        check("long.nvalid", 32'(nvalid - v0), 32'd0);
        train(1, 6, 10, 5, 10, 40);
        check_report("after_long", v0, 1, 1'b0);

        // Reset in the gap after two pulses.
        v0 = nvalid;
        a0 = nabort;
        drive(1'b1, 8); drive(1'b0, 8); drive(1'b1, 8); drive(1'b0, 8);
        check("rst_gap.busy_pre", 32'(busy_hi), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_gap.busy_hi", 32'(busy_hi), 32'd0);
        check("rst_gap.busy_lo", 32'(busy_lo), 32'd0);
        check("rst_gap.cnt_hi",  32'(cnt_hi),  32'd0);
        check("rst_gap.cnt_lo",  32'(cnt_lo),  32'd0);
        drive(1'b0, 3);
        rst = 1'b0;
        drive(1'b0, 40);
        check("rst_gap.nvalid", 32'(nvalid - v0), 32'd0);
        check("rst_gap.nabort", 32'(nabort - a0), 32'd0);
        train(4, 5, 10, 5, 12, 40);
        check_report("after_rst", v0, 4, 1'b0);

        // Rise landing exactly on the gap tick extends the sequence.
        v0 = nvalid;
        train(3, 6, 8, TICK_AGE, TICK_AGE, 40);
        check_report("tick_rise", v0, 3, 1'b0);

        // Random trains and long presses, checked cycle by cycle against the model.
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(4, 0) == 0) begin
                drive(1'b1, $urandom_range(40, 25));
                drive(1'b0, 40);
            end else begin
                train($urandom_range(20, 1), DB_LEN, 12, DB_LEN, TICK_AGE,
                      $urandom_range(50, 25));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
